execute_alu_wbbuf: RTL and testbench

Result buffer stage directly downstream of the ALU output mux. Registers each 32-bit ALU result with its destination register index and commit tag, and presents it to the writeback arbiter over a valid/ready handshake. Contains a 2-entry skid buffer, so the ALU issue path never sees combinational backpressure from writeback. Optionally drives a same-cycle bypass port from the head entry.

---
 rtl/execute_alu_wbbuf_pkg.sv | 13 +
 rtl/execute_alu_wbbuf_if.sv | 34 +++
 rtl/execute_alu_wbbuf_entry.sv | 37 +++
 rtl/execute_alu_wbbuf.sv | 128 ++++++++++++
 tb/tb_execute_alu_wbbuf.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/execute_alu_wbbuf_pkg.sv
// Shared types and constants for the ALU writeback result buffer.
// Occupancy encodings and GPR index constants used by the buffer and its entries.
package execute_alu_wbbuf_pkg;
  localparam int DATA_W    = 32;
  localparam int GPR_IDX_W = 5;
  localparam logic [GPR_IDX_W-1:0] GPR_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WBBUF_EMPTY = 2'd0,
    WBBUF_HEAD  = 2'd1,
    WBBUF_FULL  = 2'd2
  } wbbuf_state_e;
endpackage

// File: rtl/execute_alu_wbbuf_if.sv
// ALU-side and writeback-side handshake bundle of the result buffer.
// slave = the buffer itself, master = whatever drives it (ALU mux + writeback arbiter).
interface execute_alu_wbbuf_if #(parameter int TAG_W = 4);
  import execute_alu_wbbuf_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [DATA_W-1:0]    i_result;
  logic [GPR_IDX_W-1:0] i_dst;
  logic [TAG_W-1:0]     i_tag;

  logic                 o_valid;
  logic                 i_ready;
  logic [DATA_W-1:0]    o_result;
  logic [GPR_IDX_W-1:0] o_dst;
  logic                 o_wen;
  logic [TAG_W-1:0]     o_tag;

  logic                 o_bypass_valid;
  logic [GPR_IDX_W-1:0] o_bypass_dst;
  logic [DATA_W-1:0]    o_bypass_data;

  modport slave (
    input  i_valid, i_result, i_dst, i_tag, i_ready,
    output o_ready, o_valid, o_result, o_dst, o_wen, o_tag,
           o_bypass_valid, o_bypass_dst, o_bypass_data
  );

  modport master (
    output i_valid, i_result, i_dst, i_tag, i_ready,
    input  o_ready, o_valid, o_result, o_dst, o_wen, o_tag,
           o_bypass_valid, o_bypass_dst, o_bypass_data
  );
endinterface

// File: rtl/execute_alu_wbbuf_entry.sv
// One buffered result: valid + result/dst/tag with load and clear.
// Clear drops only the valid bit; payload is left as-is since nothing reads it while invalid.
module execute_alu_wbbuf_entry
  import execute_alu_wbbuf_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [DATA_W-1:0]    result_d,
  input  logic [GPR_IDX_W-1:0] dst_d,
  input  logic [TAG_W-1:0]     tag_d,
  output logic                 vld_q,
  output logic [DATA_W-1:0]    result_q,
  output logic [GPR_IDX_W-1:0] dst_q,
  output logic [TAG_W-1:0]     tag_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= 1'b0;
      result_q <= '0;
      dst_q    <= '0;
      tag_q    <= '0;
    end else if (clr) begin
      vld_q    <= 1'b0;
    end else if (ld) begin
      vld_q    <= 1'b1;
      result_q <= result_d;
      dst_q    <= dst_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: rtl/execute_alu_wbbuf.sv
// ALU result buffer: 2-entry skid (head + skid) feeding the writeback arbiter.
// Define EXECUTE_ALU_WBBUF_BYPASS_EN to drive the same-cycle bypass port from the head entry.
module execute_alu_wbbuf
  import execute_alu_wbbuf_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_flush,
  execute_alu_wbbuf_if.slave bus
);

  wbbuf_state_e state, state_nxt;

  logic                 acc, hand;
  logic                 head_ld, head_clr, head_from_skid;
  logic                 skid_ld, skid_clr;

  logic                 head_vld, skid_vld;
  logic [DATA_W-1:0]    head_result, skid_result, head_result_d;
  logic [GPR_IDX_W-1:0] head_dst, skid_dst, head_dst_d;
  logic [TAG_W-1:0]     head_tag, skid_tag, head_tag_d;

  // o_ready is just the inverted skid valid flop, so i_ready never reaches it combinationally
  assign acc  = bus.i_valid && !skid_vld;
  assign hand = head_vld && bus.i_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WBBUF_EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (i_flush) begin
      head_clr  = 1'b1;
      skid_clr  = 1'b1;
      state_nxt = WBBUF_EMPTY;
    end else begin
      case (state)
        WBBUF_EMPTY: begin
          if (acc) begin
            head_ld   = 1'b1;
            state_nxt = WBBUF_HEAD;
          end
        end
        WBBUF_HEAD: begin
          if (acc && hand) begin
            head_ld = 1'b1;
          end else if (acc) begin
            skid_ld   = 1'b1;
            state_nxt = WBBUF_FULL;
          end else if (hand) begin
            head_clr  = 1'b1;
            state_nxt = WBBUF_EMPTY;
          end
        end
        WBBUF_FULL: begin
          if (hand) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_nxt      = WBBUF_HEAD;
          end
        end
        default: state_nxt = WBBUF_EMPTY;
      endcase
    end
  end

  // Skid always drains into head first, keeping strict FIFO order
  assign head_result_d = head_from_skid ? skid_result : bus.i_result;
  assign head_dst_d    = head_from_skid ? skid_dst    : bus.i_dst;
  assign head_tag_d    = head_from_skid ? skid_tag    : bus.i_tag;

  execute_alu_wbbuf_entry #(.TAG_W(TAG_W)) u_head (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (head_clr),
    .ld       (head_ld),
    .result_d (head_result_d),
    .dst_d    (head_dst_d),
    .tag_d    (head_tag_d),
    .vld_q    (head_vld),
    .result_q (head_result),
    .dst_q    (head_dst),
    .tag_q    (head_tag)
  );

  execute_alu_wbbuf_entry #(.TAG_W(TAG_W)) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (skid_clr),
    .ld       (skid_ld),
    .result_d (bus.i_result),
    .dst_d    (bus.i_dst),
    .tag_d    (bus.i_tag),
    .vld_q    (skid_vld),
    .result_q (skid_result),
    .dst_q    (skid_dst),
    .tag_q    (skid_tag)
  );

  assign bus.o_ready  = !skid_vld;
  assign bus.o_valid  = head_vld;
  assign bus.o_result = head_result;
  assign bus.o_dst    = head_dst;
  assign bus.o_tag    = head_tag;
  assign bus.o_wen    = head_vld && (head_dst != GPR_ZERO);

`ifdef EXECUTE_ALU_WBBUF_BYPASS_EN
  // Flush kills the bypass in the same cycle so squashed results never forward
  assign bus.o_bypass_valid = head_vld && (head_dst != GPR_ZERO) && !i_flush;
  assign bus.o_bypass_dst   = head_dst;
  assign bus.o_bypass_data  = head_result;
`else
  assign bus.o_bypass_valid = 1'b0;
  assign bus.o_bypass_dst   = '0;
  assign bus.o_bypass_data  = '0;
`endif

endmodule

// File: tb/tb_execute_alu_wbbuf.sv
// Bench for execute_alu_wbbuf: directed scenarios plus an in-order scoreboard on every handoff.
module tb_execute_alu_wbbuf;
  import execute_alu_wbbuf_pkg::*;

  localparam int TAG_W = 4;
`ifdef EXECUTE_ALU_WBBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk     = 1'b0;
  logic resetn  = 1'b0;
  logic i_flush = 1'b0;

  execute_alu_wbbuf_if #(.TAG_W(TAG_W)) bus();

  execute_alu_wbbuf #(.TAG_W(TAG_W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (i_flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       dst;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   n_retired = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: pop on handoff, push on accept; flush and reset discard what is pending
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sb_result", bus.o_result, mon_e.result);
          chk("sb_dst",    32'(bus.o_dst), 32'(mon_e.dst));
          chk("sb_tag",    32'(bus.o_tag), 32'(mon_e.tag));
          chk("sb_wen",    32'(bus.o_wen), 32'(mon_e.dst != 5'd0));
        end
        n_retired++;
      end
      if (i_flush) sb.delete();
      else if (bus.i_valid && bus.o_ready)
        sb.push_back('{result: bus.i_result, dst: bus.i_dst, tag: bus.i_tag});
    end
  end

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                       input logic [TAG_W-1:0] t);
    bus.i_valid  = v;
    bus.i_result = r;
    bus.i_dst    = d;
    bus.i_tag    = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    bus.i_ready = 1'b0;
    #1;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_o_wen",   32'(bus.o_wen),   32'd0);
    chk("rst_o_result", bus.o_result,    32'd0);
    chk("rst_o_dst",   32'(bus.o_dst),   32'd0);
    chk("rst_o_tag",   32'(bus.o_tag),   32'd0);
    chk("rst_byp_v",   32'(bus.o_bypass_valid), 32'd0);
    chk("rst_byp_dst", 32'(bus.o_bypass_dst),   32'd0);
    chk("rst_byp_data", bus.o_bypass_data,      32'd0);
    #11 resetn = 1'b1;
    step();

    // single result
    bus.i_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'd3, 4'd2);
    step();
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("single_valid",  32'(bus.o_valid), 32'd1);
    chk("single_wen",    32'(bus.o_wen),   32'd1);
    chk("single_result", bus.o_result,     32'h1);
    chk("single_dst",    32'(bus.o_dst),   32'd3);
    chk("single_byp_v",    32'(bus.o_bypass_valid), 32'(BYP));
    chk("single_byp_dst",  32'(bus.o_bypass_dst),   BYP ? 32'd3 : 32'd0);
    chk("single_byp_data", bus.o_bypass_data,       BYP ? 32'd1 : 32'd0);
    step();
    chk("single_drain", 32'(bus.o_valid), 32'd0);

    // backpressure: A, B fill the buffer, C must be ignored
    bus.i_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 5'd4, 4'd1);
    step();
    chk("bp_ready_after_a", 32'(bus.o_ready), 32'd1);
    drive(1'b1, 32'hBBBB_0000, 5'd5, 4'd2);
    step();
    chk("bp_ready_full", 32'(bus.o_ready), 32'd0);
    chk("bp_head_a",     bus.o_result,     32'hAAAA_0000);
    drive(1'b1, 32'hCCCC_0000, 5'd6, 4'd3);
    step();
    step();
    chk("bp_c_ignored", 32'(bus.o_ready), 32'd0);
    chk("bp_head_hold", bus.o_result,     32'hAAAA_0000);
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    bus.i_ready = 1'b1;
    step();
    chk("bp_head_b",      bus.o_result,     32'hBBBB_0000);
    chk("bp_ready_back",  32'(bus.o_ready), 32'd1);
    step();
    chk("bp_empty",       32'(bus.o_valid), 32'd0);

    // zero destination
    drive(1'b1, 32'hFFFF_FFFF, 5'd0, 4'd5);
    step();
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("zero_valid",  32'(bus.o_valid), 32'd1);
    chk("zero_wen",    32'(bus.o_wen),   32'd0);
    chk("zero_byp_v",  32'(bus.o_bypass_valid), 32'd0);
    chk("zero_result", bus.o_result,     32'hFFFF_FFFF);
    step();

    // flush while full with a new input
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 5'd7, 4'd6);
    step();
    drive(1'b1, 32'h2222_2222, 5'd8, 4'd7);
    step();
    chk("fl_full", 32'(bus.o_ready), 32'd0);
    chk("fl_pre_byp_v", 32'(bus.o_bypass_valid), 32'(BYP));
    drive(1'b1, 32'h3333_3333, 5'd9, 4'd8);
    i_flush = 1'b1;
    #1;
    chk("fl_byp_v", 32'(bus.o_bypass_valid), 32'd0);
    step();
    i_flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("fl_valid", 32'(bus.o_valid), 32'd0);
    chk("fl_ready", 32'(bus.o_ready), 32'd1);
    bus.i_ready = 1'b1;
    step();
    chk("fl_no_new", 32'(bus.o_valid), 32'd0);

    // streaming 0..7 with i_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 5'(i + 1), 4'(i));
      step();
      chk("st_valid",  32'(bus.o_valid), 32'd1);
      chk("st_result", bus.o_result,     32'(i));
      chk("st_ready",  32'(bus.o_ready), 32'd1);
    end
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    step();
    chk("st_drain", 32'(bus.o_valid), 32'd0);

    // async reset while full
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h4444_4444, 5'd10, 4'd9);
    step();
    drive(1'b1, 32'h5555_5555, 5'd11, 4'd10);
    step();
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("ar_full", 32'(bus.o_ready), 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("ar_valid",  32'(bus.o_valid), 32'd0);
    chk("ar_ready",  32'(bus.o_ready), 32'd1);
    chk("ar_result", bus.o_result,     32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    step();
    chk("ar_post_valid", 32'(bus.o_valid), 32'd0);
    drive(1'b1, 32'h6666_6666, 5'd12, 4'd11);
    step();
    drive(1'b0, 32'd0, 5'd0, 4'd0);
    chk("ar_first_acc", bus.o_result, 32'h6666_6666);
    bus.i_ready = 1'b1;
    step();
    step();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("retired",  32'(n_retired), 32'd13);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
